// File: rtl/mem_bank_reader.sv
// mem_bank_reader
// Read-side burst sequencer for the four-bank memory array. A command
// (bank, start address, word count minus one) is accepted in IDLE. The block
// then walks the shared address bus one word per cycle, captures the selected
// bank's synchronous read data into a small output FIFO and streams it out on
// a valid/ready interface with full backpressure.
//
// Ports:
//   clk, rst_n                   clock (rising edge) and async active-low reset
//   req_valid/req_ready          burst command handshake
//   req_bank, req_addr, req_len  command fields (len = words - 1)
//   mem_addr                     shared address to all four banks
//   mem_0_in..mem_3_in           registered read data from banks 0..3
//   out_valid/out_ready          output word handshake
//   out_data, out_last           streamed word and end-of-burst marker
//   busy                         high whenever the sequencer is not idle
//   done                         one-cycle pulse after the last word is taken
module mem_bank_reader #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_bank,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_0_in,
  input  logic [DATA_W-1:0] mem_1_in,
  input  logic [DATA_W-1:0] mem_2_in,
  input  logic [DATA_W-1:0] mem_3_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [1:0]        state_reg;
  logic              ready_en_reg;   // keeps req_ready low for the first cycle after reset
  logic [1:0]        bank_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] issue_cnt_reg;  // addresses still to issue after the current one
  logic              done_reg;

  // One flag per issued address travels alongside the memory's read latency.
  logic [RD_LAT-1:0] pipe_v_reg;
  logic [RD_LAT-1:0] pipe_l_reg;

  logic [DATA_W-1:0] fifo_data_reg [FIFO_DEPTH];
  logic              fifo_last_reg [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  int                inflight;
  logic              issue;
  logic              issue_last;
  logic              push;
  logic              push_last;
  logic              pop;
  logic [DATA_W-1:0] cap_data;

  // Credit check: buffered words plus words still in the read pipe must leave
  // room in the FIFO, so a captured word always has a slot waiting for it.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight += int'(pipe_v_reg[i]);
    end
  end

  assign issue      = (state_reg == ST_READ) && ((int'(count_reg) + inflight) < FIFO_DEPTH);
  assign issue_last = issue && (issue_cnt_reg == '0);
  assign push       = pipe_v_reg[RD_LAT-1];
  assign push_last  = pipe_l_reg[RD_LAT-1];
  assign pop        = out_valid && out_ready;

  // Only the bank latched with the command is ever selected.
  always_comb begin
    cap_data = mem_0_in;
    case (bank_reg)
      2'd0: cap_data = mem_0_in;
      2'd1: cap_data = mem_1_in;
      2'd2: cap_data = mem_2_in;
      default: cap_data = mem_3_in;
    endcase
  end

  assign req_ready = (state_reg == ST_IDLE) && ready_en_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = done_reg;
  assign mem_addr  = addr_reg;
  assign out_valid = (count_reg != '0);
  assign out_data  = out_valid ? fifo_data_reg[rd_ptr_reg] : '0;
  assign out_last  = out_valid ? fifo_last_reg[rd_ptr_reg] : 1'b0;

  // Sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      ready_en_reg  <= 1'b0;
      bank_reg      <= '0;
      addr_reg      <= '0;
      issue_cnt_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      done_reg     <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            bank_reg      <= req_bank;
            addr_reg      <= req_addr;
            issue_cnt_reg <= req_len;
            state_reg     <= ST_READ;
          end
        end
        ST_READ: begin
          if (issue) begin
            addr_reg <= addr_reg + ADDR_W'(1);  // natural wrap at 2^ADDR_W
            if (issue_cnt_reg == '0) begin
              state_reg <= ST_DRAIN;
            end else begin
              issue_cnt_reg <= issue_cnt_reg - ADDR_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (pop && out_last) begin
            done_reg  <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Read-latency flag pipe
  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_v_reg[gi] <= 1'b0;
          pipe_l_reg[gi] <= 1'b0;
        end else if (gi == 0) begin
          pipe_v_reg[gi] <= issue;
          pipe_l_reg[gi] <= issue_last;
        end else begin
          pipe_v_reg[gi] <= pipe_v_reg[(gi > 0) ? gi - 1 : 0];
          pipe_l_reg[gi] <= pipe_l_reg[(gi > 0) ? gi - 1 : 0];
        end
      end
    end
  endgenerate

  // Output FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_reg[i] <= '0;
        fifo_last_reg[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_data_reg[wr_ptr_reg] <= cap_data;
        fifo_last_reg[wr_ptr_reg] <= push_last;
        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

  // The credit scheme makes overflow impossible; flag it if it ever happens.
  always @(posedge clk) begin
    if (rst_n && push && !pop) begin
      assert (count_reg < CNT_W'(FIFO_DEPTH));
    end
  end

endmodule

// File: doc/mem_bank_reader.md
Name: mem_bank_reader

Overview:
- Read-side sequencer for the four-bank 1K x 8 memory array.
- The existing write path chooses one bank via decoded write enables. This block is the read side: it accepts a burst read command (bank, start address, length) and drives the shared address bus.
- It captures the selected bank's synchronous read data and streams it out on a valid/ready interface with full backpressure.
- Sits between the memory array's parallel read outputs and any downstream consumer (UART TX, display, checker).

Parameters:
- ADDR_W, 10, address width of each bank (1024 words).
- DATA_W, 8, word width.
- RD_LAT, 1, cycles from mem_addr valid to word valid on mem_N_in (memory registers address on clock edge).
- FIFO_DEPTH, 3, output buffer entries; must be >= RD_LAT+2 to allow one word per cycle.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  burst command valid.
- req_ready  output  1  block can accept a command.
- req_bank  input  2  bank to read (0..3).
- req_addr  input  ADDR_W  first address.
- req_len  input  ADDR_W  word count minus 1 (0 -> 1 word, 1023 -> 1024 words).
- mem_addr  output  ADDR_W  shared address to all four banks.
- mem_0_in, mem_1_in, mem_2_in, mem_3_in  input  DATA_W each  read data from banks 0..3.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts word.
- out_data  output  DATA_W  streamed word.
- out_last  output  1  marks final word of the burst.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when the last word is accepted downstream.

Behaviour:
- Reset (async, rst_n=0) forces all outputs low: mem_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, req_ready=0. Reset also empties the FIFO and clears in-flight flags and counters; state goes to IDLE. Once rst_n is deasserted, req_ready=1 from the next cycle.
- FSM states:
  - IDLE: req_ready=1. On req_valid&req_ready, latch bank/addr/len into registers, set mem_addr<=req_addr and issue_cnt<=req_len, and go to READ.
  - READ: issue one address per cycle while credit>0, where credit = FIFO_DEPTH - fifo_count - inflight, computed from registered values. Each issue asserts a 1-bit flag in an RD_LAT-deep shift pipe. The flag is tagged last when issue_cnt==0. After issuing, mem_addr increments; it wraps from 2^ADDR_W-1 to 0. Once the last address is issued, go to DRAIN. While stalled (credit==0), mem_addr holds.
  - DRAIN: no new issues. When the pipe flag emerges, capture the word; leave when the last word is accepted downstream (out_valid&out_ready&out_last). On that exit, done=1 for one cycle and go to IDLE. A 1-word burst (len=0) passes READ in one cycle.
- Capture: when a pipe flag exits, write the latched bank's mem_N_in into the FIFO together with its last tag. The bank mux uses the latched bank only; req_bank changes mid-burst have no effect.
- Output: out_valid = FIFO not empty; out_data and out_last come from the FIFO head. Simultaneous push and pop keeps the count unchanged. The FIFO never overflows by construction; overflow is an assertion failure.
- Latency: command accepted in cycle 0 -> mem_addr=start in cycle 1 -> data on mem_N_in in cycle 2 -> out_valid=1 in cycle 3.
- Throughput: one word per cycle with out_ready held high.
- req_ready=0 in READ and DRAIN; new commands wait.
- Reset mid-burst discards all in-flight and buffered words; done does not pulse.

Test Plan:
- Preload bank 2 with mem[A]=A[7:0]. Request bank=2, addr=0x010, len=3 with out_ready=1 -> out_data 0x10,0x11,0x12,0x13 in consecutive cycles, first in cycle 3. out_last on 0x13; done one cycle later; req_ready back to 1.
- Wrap: bank 0, addr=0x3FE, len=3 -> mem_addr sequence 0x3FE,0x3FF,0x000,0x001; data follows the same order.
- Backpressure: bank 1, len=7, out_ready toggles 1,0,0,1 repeating -> all 8 words delivered in order with none lost or duplicated. fifo_count never exceeds 3; mem_addr holds while credit==0.
- Single word plus bank isolation: banks 0..3 hold distinct patterns (0xA0,0xB1,0xC2,0xD3 at addr 5). Request bank=3, addr=5, len=0 -> exactly one word 0xD3 with out_last=1. req_valid is ignored while busy=1.
- Reset mid-burst: assert rst_n=0 during word 4 of a len=15 burst -> out_valid=0 and busy=0 immediately, no done pulse. A new request after release returns the correct data from its own start address.
